// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter with request-to-send,
// odd parity, device ACK check and inter-edge timeout.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       done_o,
    output logic       err_o
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    frame_q, frame_d;
    logic          data_oe_q, data_oe_d;
    logic          clk_s, data_s, fall, busy;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;
    assign busy   = state_q inside {SEND, ACK, WAIT_IDLE};

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        tmo_d     = busy ? (fall ? '0 : tmo_q + 1'b1) : tmo_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        case (state_q)
            IDLE: if (tx_valid_i) begin
                frame_d = {1'b1, ~^tx_data_i, tx_data_i};
                inh_d   = '0;
                state_d = INHIBIT;
            end
            INHIBIT: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end
            end
            RTS: begin
                tmo_d   = '0;
                bit_d   = '0;
                state_d = SEND;
            end
            // frame_q holds data LSB first, then parity, then stop
            SEND: if (fall) begin
                data_oe_d = ~frame_q[bit_q];
                bit_d     = bit_q + 1'b1;
                if (bit_q == 4'd9) state_d = ACK;
            end
            ACK: if (fall) begin
                bit_d   = bit_q + 1'b1;
                state_d = data_s ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_s && data_s) state_d = DONE;
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        if (busy && !fall && tmo_q == TMO_LAST) begin
            data_oe_d = 1'b0;
            state_d   = ERR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            inh_q       <= '0;
            tmo_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_s;
            inh_q       <= inh_d;
            tmo_q       <= tmo_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign tx_ready_o    = state_q == IDLE;
    assign ps2_clk_oe_o  = state_q inside {INHIBIT, RTS};
    assign ps2_data_oe_o = data_oe_q;
    assign done_o        = state_q == DONE;
    assign err_o         = state_q == ERR;
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with an open-drain PS/2 device model
// that can ACK, NACK or stay silent.
module tb_ps2_tx;
    localparam int INH    = 60;
    localparam int TMO    = 1000;
    localparam int HALF   = 20;
    localparam int M_ACK  = 0;
    localparam int M_NACK = 1;
    localparam int M_SIL  = 2;

    typedef struct {
        logic [10:0] frame;
        logic        ok;
        logic        tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk, ps2_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, clk_oe, data_oe, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    int         dev_mode = M_SIL;
    int         cyc = 0;
    int         t_rel = 0;
    int         pass_cnt = 0;
    int         tot_cnt = 0;
    logic [10:0] obs_frame = '0;
    exp_t       exp_q[$];

    assign ps2_clk  = !(clk_oe || dev_clk_low);
    assign ps2_data = !(data_oe || dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .ps2_clk_oe_o(clk_oe), .ps2_data_oe_o(data_oe), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Device: times the inhibit, then clocks the frame in, sampling on rising edges
    initial begin
        logic [10:0] obs;
        int n;
        forever begin
            @(negedge clk);
            if (clk_oe) begin
                n = 0;
                while (clk_oe) begin
                    n++;
                    @(negedge clk);
                end
                check("inhibit_len", n, INH + 1);
                check("start_drive", data_oe, 1);
                t_rel = cyc;
                if (dev_mode != M_SIL) begin
                    repeat (5) @(negedge clk);
                    obs[0] = ps2_data;
                    for (int i = 1; i <= 10; i++) begin
                        dev_clk_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        dev_clk_low = 1'b0;
                        obs[i] = ps2_data;
                        repeat (HALF) @(negedge clk);
                    end
                    obs_frame = obs;
                    if (dev_mode == M_ACK) dev_data_low = 1'b1;
                    repeat (5) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (5) @(negedge clk);
                    dev_data_low = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic chk_next;
        chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                check("ready_after_pulse", tx_ready, 1);
                chk_next = 1'b0;
            end
            if (done || err) begin
                if (exp_q.size() == 0) check("unexpected_pulse", {done, err}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("outcome", {done, err}, e.ok ? 2'b10 : 2'b01);
                    if (e.tmo) check("timeout_cycles", cyc - t_rel, TMO);
                    else check("frame", obs_frame, e.frame);
                    check("ready_in_pulse", tx_ready, 0);
                    check("oe_in_pulse", {clk_oe, data_oe}, 0);
                    chk_next = 1'b1;
                end
            end
        end
    end

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (60) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int mode, input logic [10:0] fr,
                        input logic ok, input logic tmo);
        dev_mode = mode;
        exp_q.push_back('{frame: fr, ok: ok, tmo: tmo});
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_drop", tx_ready, 0);
        drain(5000);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_oe", {clk_oe, data_oe}, 0);
        check("rst_pulses", {done, err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        dev_mode = M_SIL;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 500 && !(data_oe && !clk_oe); i++) @(negedge clk);
        check("midframe_reached", {clk_oe, data_oe}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_oe", {clk_oe, data_oe}, 0);
        check("async_rst_ready", tx_ready, 1);
        check("async_rst_pulses", {done, err}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hED, M_ACK,  {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 1'b0);
        send(8'hF4, M_ACK,  {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1, 1'b0);
        send(8'h00, M_ACK,  {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0);
        send(8'hA5, M_NACK, {1'b1, 1'b1, 8'hA5, 1'b0}, 1'b0, 1'b0);
        send(8'h3C, M_SIL,  '0, 1'b0, 1'b1);

        dev_mode = M_ACK;
        exp_q.push_back('{frame: {1'b1, 1'b0, 8'hF4, 1'b0}, ok: 1'b1, tmo: 1'b0});
        exp_q.push_back('{frame: {1'b1, 1'b1, 8'h00, 1'b0}, ok: 1'b1, tmo: 1'b0});
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        repeat (100) @(negedge clk);
        tx_data = 8'h00;
        for (int i = 0; i < 3000 && exp_q.size() > 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        drain(5000);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
